// File: rtl/piso_serializer_pkg.sv
// Shared types and constants for the serial link (serializer and downstream deserialiser).
// Holds the state encoding, the counter-width helper and the default word length.
package piso_serializer_pkg;

   localparam int SER_WIDTH = 4;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_t;

   // Counter width for a down-counter spanning 0..n-1; never narrower than one bit.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage: takes a word on valid/ready and emits it MSB first,
// one bit per clk, streaming back-to-back words without an idle bit between them.
module piso_serializer
   import piso_serializer_pkg::*;
#(
   parameter int WIDTH = SER_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             out,
   output logic             out_valid,
   output logic             word_done,
   output logic             busy
);

   localparam int CNT_W = clog2_min1(WIDTH);

   ser_state_t       state;
   logic [WIDTH-1:0] shreg;
   logic [CNT_W-1:0] cnt;
   logic             last_bit;
   logic             can_load;

   assign last_bit = (state == SHIFT) && (cnt == '0);
   // A new word may land on the same edge the last bit leaves, so no gap appears.
   assign can_load = (state == IDLE) || (cnt == '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         shreg <= '0;
         cnt   <= '0;
      end else if (in_valid && can_load) begin
         state <= SHIFT;
         shreg <= in_data;
         cnt   <= CNT_W'(WIDTH - 1);
      end else if (state == SHIFT) begin
         if (cnt != '0) begin
            shreg <= shreg << 1;
            cnt   <= cnt - CNT_W'(1);
         end else begin
            state <= IDLE;
         end
      end
   end

   assign in_ready  = rst_n && can_load;
   assign out       = (state == SHIFT) && shreg[WIDTH-1];
   assign out_valid = (state == SHIFT);
   assign busy      = (state == SHIFT);
   assign word_done = last_bit;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench: a WIDTH=4 serializer feeding a downstream SIPO register, plus a WIDTH=1 instance.
module tb_piso_serializer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] in_data4;
   logic       in_valid4;
   logic       in_ready4, out4, out_valid4, word_done4, busy4;
   logic [0:0] in_data1;
   logic       in_valid1;
   logic       in_ready1, out1, out_valid1, word_done1, busy1;
   logic [3:0] sipo;
   int         wd_cnt;
   int         errors = 0;
   int         checks = 0;

   always #5 clk = ~clk;

   piso_serializer #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data4), .in_valid(in_valid4),
      .in_ready(in_ready4), .out(out4), .out_valid(out_valid4),
      .word_done(word_done4), .busy(busy4)
   );

   piso_serializer #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data1), .in_valid(in_valid1),
      .in_ready(in_ready1), .out(out1), .out_valid(out_valid1),
      .word_done(word_done1), .busy(busy1)
   );

   // Downstream serial-in parallel-out register on the common clock.
   always @(posedge clk) sipo <= {sipo[2:0], out4};

   always @(negedge clk) if (word_done4) wd_cnt++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] w;
      logic [7:0] seq;
      int         wd_before;
      sipo = '0; wd_cnt = 0;
      rst_n = 1'b0; in_valid4 = 1'b0; in_data4 = '0; in_valid1 = 1'b0; in_data1 = '0;

      // Reset then idle
      step(); step();
      chk("rst out", out4, 1'b0);
      chk("rst out_valid", out_valid4, 1'b0);
      chk("rst busy", busy4, 1'b0);
      chk("rst word_done", word_done4, 1'b0);
      chk("rst in_ready low", in_ready4, 1'b0);
      rst_n = 1'b1;
      #1;
      chk("idle in_ready", in_ready4, 1'b1);
      chk("idle in_ready w1", in_ready1, 1'b1);
      step();
      chk("idle out_valid", out_valid4, 1'b0);
      chk("idle busy", busy4, 1'b0);

      // Single word 1011
      w = 4'b1011;
      in_data4 = w; in_valid4 = 1'b1;
      step();
      in_valid4 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("single bit%0d", i), out4, w[3-i]);
         chk($sformatf("single vld%0d", i), out_valid4, 1'b1);
         chk($sformatf("single wd%0d", i), word_done4, (i == 3));
         if (i < 3) step();
      end
      step();
      chk("single sipo", sipo, 4'b1011);
      chk("single vld after", out_valid4, 1'b0);
      chk("single out after", out4, 1'b0);

      // Back-to-back 1100 then 0110
      seq = 8'b1100_0110;
      in_data4 = 4'b1100; in_valid4 = 1'b1;
      step();
      for (int c = 1; c <= 8; c++) begin
         chk($sformatf("b2b bit%0d", c), out4, seq[8-c]);
         chk($sformatf("b2b vld%0d", c), out_valid4, 1'b1);
         chk($sformatf("b2b rdy%0d", c), in_ready4, (c == 4 || c == 8));
         chk($sformatf("b2b wd%0d", c), word_done4, (c == 4 || c == 8));
         if (c == 1) in_data4 = 4'b0110;
         if (c == 5) begin
            in_valid4 = 1'b0;
            chk("b2b sipo first", sipo, 4'b1100);
         end
         step();
      end
      chk("b2b sipo second", sipo, 4'b0110);
      chk("b2b vld after", out_valid4, 1'b0);

      // Stall: a word offered mid-flight is ignored
      w = 4'b1001;
      in_data4 = w; in_valid4 = 1'b1;
      step();
      in_valid4 = 1'b0;
      chk("stall bit1", out4, w[3]);
      step();
      chk("stall rdy low", in_ready4, 1'b0);
      in_data4 = 4'b0001; in_valid4 = 1'b1;
      step();
      in_valid4 = 1'b0;
      chk("stall bit3", out4, w[1]);
      step();
      chk("stall bit4", out4, w[0]);
      step();
      chk("stall sipo", sipo, w);
      chk("stall idle vld", out_valid4, 1'b0);
      chk("stall idle busy", busy4, 1'b0);
      step();
      chk("stall no extra", out_valid4, 1'b0);

      // Reset mid-word aborts cleanly
      wd_before = wd_cnt;
      in_data4 = 4'b1111; in_valid4 = 1'b1;
      step();
      in_valid4 = 1'b0;
      step();
      rst_n = 1'b0;
      #1;
      chk("midrst rdy gated", in_ready4, 1'b0);
      step();
      chk("midrst out", out4, 1'b0);
      chk("midrst vld", out_valid4, 1'b0);
      chk("midrst wd", word_done4, 1'b0);
      rst_n = 1'b1;
      step(); step();
      chk("midrst no wd pulse", wd_cnt - wd_before, 0);
      w = 4'b0101;
      in_data4 = w; in_valid4 = 1'b1;
      step();
      in_valid4 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("post bit%0d", i), out4, w[3-i]);
         chk($sformatf("post wd%0d", i), word_done4, (i == 3));
         if (i < 3) step();
      end
      step();
      chk("post sipo", sipo, w);

      // WIDTH=1 streaming 1,0,1
      in_data1 = 1'b1; in_valid1 = 1'b1;
      step();
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("w1 bit%0d", i), out1, (i != 1));
         chk($sformatf("w1 vld%0d", i), out_valid1, 1'b1);
         chk($sformatf("w1 wd%0d", i), word_done1, 1'b1);
         chk($sformatf("w1 rdy%0d", i), in_ready1, 1'b1);
         in_data1 = (i == 0) ? 1'b0 : 1'b1;
         if (i == 2) in_valid1 = 1'b0;
         step();
      end
      chk("w1 idle vld", out_valid1, 1'b0);
      chk("w1 idle out", out1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
